// File: rtl/conv_core_param.sv
// conv_core_param: NCH-channel KxK convolution core with a double-buffered
// weight store (shadow bank written tap by tap, active bank used for compute)
// and a two-stage multiply / reduce-ReLU-saturate pipeline.
module conv_core_param #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int K     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   weight_load,
    input  logic [NCH*WIDTH-1:0]   weight_in,
    input  logic                   weight_swap,
    input  logic                   activate_ready,
    input  logic [K*K*WIDTH-1:0]   activate,
    input  logic                   relu_en,
    output logic                   weight_load_done,
    output logic                   shadow_full,
    output logic                   active_valid,
    output logic [NCH*WIDTH-1:0]   out_psum,
    output logic                   out_psum_vld
);

    localparam int N      = K * K;
    localparam int ACC_W  = 2 * WIDTH + $clog2(N) + 1;
    localparam int PROD_W = 2 * WIDTH;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    // Saturation bounds expressed at accumulator width so comparisons stay signed.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Negative sums are forced to zero when ReLU is enabled for that window.
    function automatic logic signed [ACC_W-1:0] relu_fn(
        input logic signed [ACC_W-1:0] v,
        input logic                    en
    );
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    // Clamp a wide sum into the signed WIDTH-bit output range.
    function automatic logic signed [WIDTH-1:0] sat_fn(
        input logic signed [ACC_W-1:0] v
    );
        if (v > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end
        return v[WIDTH-1:0];
    endfunction

    // Weight store control state
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             shadow_full_q, shadow_full_d;
    logic             active_valid_q, active_valid_d;
    logic             load_done_q, load_done_d;
    logic             swap_fire;
    logic             issue;

    // Weight banks
    logic signed [WIDTH-1:0] shadow_q [NCH][N];
    logic signed [WIDTH-1:0] active_q [NCH][N];

    // Stage 1: products
    logic signed [PROD_W-1:0] prod_d    [NCH][N];
    logic signed [PROD_W-1:0] prod_p1_q [NCH][N];
    logic                     vld_p1_q;
    logic                     relu_p1_q;

    // Stage 2: reduction result
    logic signed [ACC_W-1:0]  acc_d [NCH];
    logic [NCH*WIDTH-1:0]     psum_d;
    logic [NCH*WIDTH-1:0]     out_psum_p2_q;
    logic                     vld_p2_q;

    // Next-state logic for the write index, bank flags and load-done pulse.
    always_comb begin
        idx_d          = idx_q;
        shadow_full_d  = shadow_full_q;
        active_valid_d = active_valid_q;
        load_done_d    = 1'b0;
        swap_fire      = weight_swap && shadow_full_q;
        issue          = activate_ready && active_valid_q;

        // A swap consumes the completed set; a write at idx 0 starts a new one.
        if (swap_fire) begin
            shadow_full_d  = 1'b0;
            active_valid_d = 1'b1;
        end
        if (weight_load) begin
            if (idx_q == '0) begin
                shadow_full_d = 1'b0;
            end
            if (idx_q == IDX_LAST) begin
                shadow_full_d = 1'b1;
                load_done_d   = 1'b1;
                idx_d         = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q          <= '0;
            shadow_full_q  <= 1'b0;
            active_valid_q <= 1'b0;
            load_done_q    <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            shadow_full_q  <= shadow_full_d;
            active_valid_q <= active_valid_d;
            load_done_q    <= load_done_d;
        end
    end

    // Shadow bank takes one tap per channel per load; swap copies the pre-write shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < N; i++) begin
                    shadow_q[c][i] <= '0;
                    active_q[c][i] <= '0;
                end
            end
        end else begin
            if (swap_fire) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int i = 0; i < N; i++) begin
                        active_q[c][i] <= shadow_q[c][i];
                    end
                end
            end
            if (weight_load) begin
                for (int c = 0; c < NCH; c++) begin
                    shadow_q[c][idx_q] <= $signed(weight_in[c*WIDTH +: WIDTH]);
                end
            end
        end
    end

    // Per-tap signed products against the active bank (old weights on a swap cycle).
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < N; i++) begin
                prod_d[c][i] = '0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < N; i++) begin
                prod_d[c][i] = PROD_W'(active_q[c][i])
                             * PROD_W'($signed(activate[i*WIDTH +: WIDTH]));
            end
        end
    end

    // ---- stage 1 boundary: products, issue flag and ReLU enable ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            relu_p1_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < N; i++) begin
                    prod_p1_q[c][i] <= '0;
                end
            end
        end else begin
            vld_p1_q  <= issue;
            relu_p1_q <= relu_en;
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < N; i++) begin
                    prod_p1_q[c][i] <= prod_d[c][i];
                end
            end
        end
    end

    // Reduce products per channel at full width, then ReLU and saturate.
    always_comb begin
        psum_d = '0;
        for (int c = 0; c < NCH; c++) begin
            acc_d[c] = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < N; i++) begin
                acc_d[c] = acc_d[c] + ACC_W'(prod_p1_q[c][i]);
            end
            psum_d[c*WIDTH +: WIDTH] = sat_fn(relu_fn(acc_d[c], relu_p1_q));
        end
    end

    // ---- stage 2 boundary: output register holds its value between results ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_psum_p2_q <= '0;
            vld_p2_q      <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                out_psum_p2_q <= psum_d;
            end
        end
    end

    assign weight_load_done = load_done_q;
    assign shadow_full      = shadow_full_q;
    assign active_valid     = active_valid_q;
    assign out_psum         = out_psum_p2_q;
    assign out_psum_vld     = vld_p2_q;

endmodule

// File: tb/tb_conv_core_param.sv
// Bench for conv_core_param: constant-expectation vector table, hand-written
// multi-cycle sequences, and randomized traffic against a dot-product model.
module tb_conv_core_param;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int K     = 3;
    localparam int N     = K * K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, weight_load, weight_swap, activate_ready, relu_en;
    logic [NCH*WIDTH-1:0] weight_in, out_psum;
    logic [N*WIDTH-1:0]   activate;
    logic                 weight_load_done, shadow_full, active_valid, out_psum_vld;

    conv_core_param #(.WIDTH(WIDTH), .NCH(NCH), .K(K)) dut (
        .clk(clk), .rst(rst),
        .weight_load(weight_load), .weight_in(weight_in), .weight_swap(weight_swap),
        .activate_ready(activate_ready), .activate(activate), .relu_en(relu_en),
        .weight_load_done(weight_load_done), .shadow_full(shadow_full),
        .active_valid(active_valid), .out_psum(out_psum), .out_psum_vld(out_psum_vld)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: weight sets as integer arrays, results as integers.
    int m_sh [NCH][N];
    int m_ac [NCH][N];
    int m_idx;
    bit m_full, m_aval, m_done;
    bit s1_v, o_v;
    int s1_r [NCH];
    int o_r  [NCH];

    typedef struct {
        logic [NCH*WIDTH-1:0] w;
        logic [N*WIDTH-1:0]   a;
        logic                 relu;
        logic [NCH*WIDTH-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    function automatic int sx(input logic [WIDTH-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [NCH*WIDTH-1:0] pack_exp();
        logic [NCH*WIDTH-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c*WIDTH +: WIDTH] = WIDTH'(o_r[c]);
        return r;
    endfunction

    function automatic logic [N*WIDTH-1:0] rnd_act();
        logic [N*WIDTH-1:0] r;
        for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic model_step();
        int res [NCH];
        bit issue, swp;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < N; i++) begin
                    m_sh[c][i] = 0;
                    m_ac[c][i] = 0;
                end
                s1_r[c] = 0;
                o_r[c]  = 0;
            end
            m_idx = 0; m_full = 0; m_aval = 0; m_done = 0; s1_v = 0; o_v = 0;
            return;
        end
        issue = activate_ready && m_aval;
        for (int c = 0; c < NCH; c++) begin
            int dot;
            dot = 0;
            for (int i = 0; i < N; i++) dot += m_ac[c][i] * sx(activate[i*WIDTH +: WIDTH]);
            if (relu_en && dot < 0) dot = 0;
            res[c] = clamp(dot);
        end
        o_v = s1_v;
        if (s1_v) o_r = s1_r;
        s1_v = issue;
        s1_r = res;
        swp = weight_swap && m_full;
        if (swp) begin
            m_ac   = m_sh;
            m_aval = 1;
            m_full = 0;
        end
        m_done = weight_load && (m_idx == N - 1);
        if (weight_load) begin
            for (int c = 0; c < NCH; c++) m_sh[c][m_idx] = sx(weight_in[c*WIDTH +: WIDTH]);
            if (m_idx == 0) m_full = 0;
            if (m_idx == N - 1) begin
                m_full = 1;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("model_vld",  64'(out_psum_vld), 64'(o_v));
        chk("model_psum", 64'(out_psum), 64'(pack_exp()));
        chk("model_done", 64'(weight_load_done), 64'(m_done));
        chk("model_full", 64'(shadow_full), 64'(m_full));
        chk("model_aval", 64'(active_valid), 64'(m_aval));
    endtask

    task automatic set_idle();
        rst = 0; weight_load = 0; weight_swap = 0; activate_ready = 0; relu_en = 0;
    endtask

    task automatic load_set(input logic [NCH*WIDTH-1:0] w, input string nm);
        for (int k = 0; k < N; k++) begin
            weight_load = 1;
            weight_in   = w;
            cyc();
            chk(nm, 64'(weight_load_done), 64'(k == N - 1));
        end
        weight_load = 0;
    endtask

    initial begin
        int seen, run, best;
        logic [NCH*WIDTH-1:0] w1, w2;

        // ch3..ch0 packing
        tbl[0] = '{w: {8'h00, 8'hFF, 8'h02, 8'h01}, a: {N{8'h03}}, relu: 1'b0,
                   exp: {8'h00, 8'hE5, 8'h36, 8'h1B}};
        tbl[1] = '{w: {NCH{8'h7F}}, a: {N{8'h7F}}, relu: 1'b0, exp: {NCH{8'h7F}}};
        tbl[2] = '{w: {NCH{8'h80}}, a: {N{8'h7F}}, relu: 1'b0, exp: {NCH{8'h80}}};
        tbl[3] = '{w: {NCH{8'h80}}, a: {N{8'h7F}}, relu: 1'b1, exp: {NCH{8'h00}}};
        tbl[4] = '{w: {8'hFB, 8'h05, 8'h80, 8'h7F}, a: {N{8'hFE}}, relu: 1'b1,
                   exp: {8'h5A, 8'h00, 8'h7F, 8'h00}};
        tbl[5] = '{w: {8'hFD, 8'h03, 8'h01, 8'hFF}, a: {N{8'hF9}}, relu: 1'b0,
                   exp: {8'h7F, 8'h80, 8'hC1, 8'h3F}};

        set_idle();
        weight_in = '0;
        activate  = '0;

        // Reset state, with activate_ready asserted to show reset priority.
        rst = 1; activate_ready = 1;
        cyc(); cyc();
        set_idle();
        chk("rst_vld",  64'(out_psum_vld), 64'd0);
        chk("rst_psum", 64'(out_psum), 64'd0);
        chk("rst_aval", 64'(active_valid), 64'd0);
        chk("rst_full", 64'(shadow_full), 64'd0);

        // Compute request with no active set must never produce a result.
        seen = 0;
        activate_ready = 1; activate = rnd_act();
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (out_psum_vld) seen++;
        end
        activate_ready = 0;
        chk("noaval_vld", 64'(seen), 64'd0);

        // Vector table: load, swap, issue one window, check result and hold.
        for (int t = 0; t < 6; t++) begin
            load_set(tbl[t].w, "tbl_done");
            chk("tbl_full", 64'(shadow_full), 64'd1);
            weight_swap = 1; cyc(); weight_swap = 0;
            chk("tbl_swap_aval", 64'(active_valid), 64'd1);
            chk("tbl_swap_full", 64'(shadow_full), 64'd0);
            activate_ready = 1; activate = tbl[t].a; relu_en = tbl[t].relu;
            cyc();
            activate_ready = 0; relu_en = 0; activate = rnd_act();
            chk("tbl_lat1_vld", 64'(out_psum_vld), 64'd0);
            cyc();
            chk("tbl_vld",  64'(out_psum_vld), 64'd1);
            chk("tbl_psum", 64'(out_psum), 64'(tbl[t].exp));
            cyc();
            chk("tbl_hold_vld",  64'(out_psum_vld), 64'd0);
            chk("tbl_hold_psum", 64'(out_psum), 64'(tbl[t].exp));
        end

        // Swap after a partial load is ignored; active set is the last table entry.
        for (int k = 0; k < 5; k++) begin
            weight_load = 1; weight_in = {NCH{8'h11}}; cyc();
        end
        weight_load = 0;
        weight_swap = 1; cyc(); weight_swap = 0;
        chk("partial_full", 64'(shadow_full), 64'd0);
        activate_ready = 1; activate = {N{8'h01}}; cyc();
        activate_ready = 0; cyc();
        chk("partial_vld",  64'(out_psum_vld), 64'd1);
        chk("partial_psum", 64'(out_psum), 64'({8'hE5, 8'h1B, 8'h09, 8'hF7}));

        // Reset at idx=5 with two computes in flight.
        activate_ready = 1; activate = rnd_act(); cyc();
        rst = 1; activate = rnd_act(); cyc();
        set_idle();
        chk("mid_rst_vld",  64'(out_psum_vld), 64'd0);
        chk("mid_rst_psum", 64'(out_psum), 64'd0);
        chk("mid_rst_done", 64'(weight_load_done), 64'd0);
        chk("mid_rst_full", 64'(shadow_full), 64'd0);
        chk("mid_rst_aval", 64'(active_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (out_psum_vld) seen++;
        end
        chk("mid_rst_novld", 64'(seen), 64'd0);
        load_set({NCH{8'h05}}, "fresh_done");

        // Overlap: stream 20 windows, load a new set meanwhile, swap at window 10.
        w1 = 32'($urandom);
        w2 = 32'($urandom);
        load_set(w1, "ovl_done1");
        weight_swap = 1; cyc(); weight_swap = 0;
        run = 0; best = 0; seen = 0;
        for (int k = 0; k < 23; k++) begin
            activate_ready = (k < 20);
            activate       = rnd_act();
            relu_en        = 1'($urandom_range(0, 1));
            weight_load    = (k < N);
            weight_in      = w2;
            weight_swap    = (k == 10);
            cyc();
            if (out_psum_vld) begin
                seen++; run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        set_idle();
        chk("ovl_vld_count", 64'(seen), 64'd20);
        chk("ovl_vld_run",   64'(best), 64'd20);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst            = ($urandom_range(0, 149) == 0);
            weight_load    = 1'($urandom_range(0, 1));
            weight_in      = 32'($urandom);
            weight_swap    = ($urandom_range(0, 3) == 0);
            activate_ready = 1'($urandom_range(0, 1));
            activate       = rnd_act();
            relu_en        = 1'($urandom_range(0, 1));
            cyc();
        end
        set_idle();
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_core_param.md
CONV_CORE_PARAM -- requirements
Module: conv_core_param

Interface
REQ-001 Parameter WIDTH, default 8: signed bit width of every weight, activation and output element.
REQ-002 Parameter NCH, default 4: number of output channels (filters), NCH >= 1.
REQ-003 Parameter K, default 3: kernel side length, K >= 1; N = K*K taps per filter.
REQ-004 Derived ACC_W = 2*WIDTH + clog2(N) + 1: internal accumulator width, never user-set.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 weight_load  in  1  writes one tap per channel into the shadow bank this cycle.
REQ-008 weight_in  in  NCH*WIDTH  tap value per channel; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 weight_swap  in  1  request to copy the shadow bank into the active bank.
REQ-010 activate_ready  in  1  the activate window is valid this cycle.
REQ-011 activate  in  N*WIDTH  KxK window; tap i = r*K+col occupies bits [i*WIDTH +: WIDTH].
REQ-012 relu_en  in  1  clamps negative results to 0; sampled with activate_ready.
REQ-013 weight_load_done  out  1  one-cycle pulse: shadow bank fully written.
REQ-014 shadow_full  out  1  shadow bank holds a complete, unswapped filter set.
REQ-015 active_valid  out  1  active bank holds a swapped-in filter set.
REQ-016 out_psum  out  NCH*WIDTH  saturated result per channel, same packing as weight_in.
REQ-017 out_psum_vld  out  1  out_psum is valid this cycle.

Function
REQ-018 Weight write: when weight_load=1, shadow[c][idx] <= weight_in slice c for every c; idx advances by 1 and wraps from N-1 to 0.
REQ-019 weight_load_done is registered and pulses the cycle after the write at idx=N-1; shadow_full sets on the same edge.
REQ-020 A weight_load write at idx=0 clears shadow_full; a partially written shadow bank is never swappable.
REQ-021 Swap: weight_swap=1 with shadow_full=1 copies every shadow tap to active, sets active_valid and clears shadow_full on that edge; weight_swap with shadow_full=0 is ignored.
REQ-022 weight_swap and a weight_load write at idx=0 in the same cycle: the completed shadow set is swapped, then the new write proceeds; shadow_full ends at 0.
REQ-023 Loading the shadow bank while computing is legal and never affects results that use the active bank.
REQ-024 A compute is issued when activate_ready=1 and active_valid=1; activate_ready is ignored while active_valid=0.
REQ-025 A compute issued in the same cycle as a swap uses the old active weights; the first compute after the swap edge uses the new ones.
REQ-026 Pipeline stage 1 registers all NCH*N signed products w[c][i]*a[i] (2*WIDTH bits each), plus the issue flag and relu_en.
REQ-027 Pipeline stage 2 sums the N products per channel in ACC_W bits, applies ReLU if enabled, saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and registers the result into out_psum.
REQ-028 Latency: out_psum_vld asserts exactly 2 cycles after an issue cycle; full throughput of one issue per cycle; no backpressure.
REQ-029 out_psum holds its last value while out_psum_vld=0.

Reset
REQ-030 rst=1 on an edge clears all shadow and active taps, idx, shadow_full, active_valid, weight_load_done, both pipeline stages, out_psum and out_psum_vld to 0.
REQ-031 rst has priority over every other input; in-flight computes are dropped and never produce out_psum_vld.

Verification (WIDTH=8, NCH=4, K=3)
REQ-032 Basic: load 9 cycles with ch0=1, ch1=2, ch2=-1, ch3=0, then swap, then activate all taps=3 -> weight_load_done pulses 1 cycle after the 9th write; 2 cycles after issue out_psum = {0,-27,54,27} (ch3..ch0) with vld=1.
REQ-033 Saturation: all taps w=127, a=127 -> 127; w=-128, a=127 -> -128; the same with relu_en=1 -> 0.
REQ-034 Overlap: stream 20 back-to-back windows while loading a new set, swap at window 10 -> windows 0..10 use the old weights, windows 11..19 use the new; vld stays high for 20 consecutive cycles.
REQ-035 Guards: weight_swap after only 5 writes -> active unchanged and shadow_full=0; activate_ready with active_valid=0 -> out_psum_vld never asserts.
REQ-036 Reset mid-operation: rst at idx=5 with 2 computes in flight -> no vld appears; done pulses only after 9 fresh writes; all outputs read 0 the cycle after reset.
